// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM states and access-size helper for the data memory
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    // Access size in bytes: 1, 2, 4 or 8.
    function automatic logic [3:0] size_of(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane alignment: store shift/byte-enables and load extract/extend
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 64,
    localparam int BYTES = XLEN / 8,
    localparam int LW = $clog2(BYTES)
) (
    input  logic [XLEN-1:0]  i_wdata,
    input  logic [LW-1:0]    i_lane,
    input  logic [3:0]       i_size,
    output logic [XLEN-1:0]  o_wdata_sh,
    output logic [BYTES-1:0] o_be,
    input  logic [XLEN-1:0]  i_word,
    input  logic [2:0]       i_funct3,
    output logic [XLEN-1:0]  o_rdata
);

    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_mask;
    logic [3:0]      w_ld_size;
    logic            w_sign;

    assign o_wdata_sh = i_wdata << {i_lane, 3'b000};
    assign o_be       = ~({BYTES{1'b1}} << i_size) << i_lane;

    assign w_sh      = i_word >> {i_lane, 3'b000};
    assign w_ld_size = size_of(i_funct3);
    // A shift by the full width yields zero, so a doubleword gives an all-ones mask.
    assign w_mask    = ~({XLEN{1'b1}} << {w_ld_size, 3'b000});

    always_comb begin
        w_sign = 1'b0;
        case (i_funct3[1:0])
            2'b00:   w_sign = w_sh[7];
            2'b01:   w_sign = w_sh[15];
            2'b10:   w_sign = w_sh[31];
            default: w_sign = w_sh[XLEN-1];
        endcase
        w_sign = w_sign & ~i_funct3[2];
    end

    assign o_rdata = (w_sh & w_mask) | (w_sign ? ~w_mask : '0);

endmodule

// File: rtl/data_memory_sized.sv
// rtl/data_memory_sized.sv - MEM-stage data memory with sized loads/stores, fault checks and post-reset clear sweep
module data_memory_sized
    import dmem_pkg::*;
#(
    parameter int              XLEN           = 64,
    parameter int              DEPTH          = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR      = '0,
    parameter int              CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [XLEN-1:0] req_addr,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault,
    output logic            busy
);

    localparam int     BYTES       = XLEN / 8;
    localparam int     LW          = $clog2(BYTES);
    localparam int     IW          = $clog2(DEPTH);
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

    logic [XLEN-1:0] r_mem [DEPTH];
    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_clear_idx;
    logic            r_rsp_valid;
    logic [XLEN-1:0] r_rsp_rdata;
    logic            r_rsp_fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RESET_STATE;
            r_clear_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR)
                r_clear_idx <= r_clear_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_CLEAR: begin
                busy = 1'b1;
                if (r_clear_idx == IW'(DEPTH - 1))
                    w_state_nxt = S_READY;
            end
            S_READY: req_ready = 1'b1;
            default: w_state_nxt = RESET_STATE;
        endcase
    end

    logic [XLEN-1:0]  w_off;
    logic [3:0]       w_size;
    logic [LW-1:0]    w_lane;
    logic [IW-1:0]    w_idx;
    logic             w_fault;
    logic             w_accept;
    logic [XLEN-1:0]  w_word;
    logic [XLEN-1:0]  w_wdata_sh;
    logic [BYTES-1:0] w_be;
    logic [XLEN-1:0]  w_bitmask;
    logic [XLEN-1:0]  w_ld_rdata;

    // Unsigned offset: an address below BASE_ADDR wraps high and lands in the range fault.
    assign w_off    = req_addr - BASE_ADDR;
    assign w_size   = size_of(req_funct3);
    assign w_lane   = w_off[LW-1:0];
    assign w_idx    = w_off[LW+IW-1:LW];
    assign w_word   = r_mem[w_idx];
    assign w_accept = req_valid && req_ready;

    assign w_fault = (|w_off[XLEN-1:LW+IW])
                   | (|(4'(w_lane) & (w_size - 4'd1)))
                   | (w_size > 4'(BYTES))
                   | (req_write ? req_funct3[2] : (req_funct3 == 3'b111));

    dmem_lane_align #(.XLEN(XLEN)) u_align (
        .i_wdata    (req_wdata),
        .i_lane     (w_lane),
        .i_size     (w_size),
        .o_wdata_sh (w_wdata_sh),
        .o_be       (w_be),
        .i_word     (w_word),
        .i_funct3   (req_funct3),
        .o_rdata    (w_ld_rdata)
    );

    for (genvar g = 0; g < BYTES; g++) begin : g_bitmask
        assign w_bitmask[8*g +: 8] = {8{w_be[g]}};
    end

    always_ff @(posedge clk) begin
        if (busy)
            r_mem[r_clear_idx] <= '0;
        else if (w_accept && req_write && !w_fault)
            r_mem[w_idx] <= (w_word & ~w_bitmask) | (w_wdata_sh & w_bitmask);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_fault <= w_fault;
                r_rsp_rdata <= (w_fault || req_write) ? '0 : w_ld_rdata;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_fault = r_rsp_fault;

endmodule

// File: tb/tb_data_memory_sized.sv
// tb/tb_data_memory_sized.sv - directed self-checking bench for data_memory_sized
module tb_data_memory_sized;
    import dmem_pkg::*;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        req_valid  = 1'b0;
    logic        req_write  = 1'b0;
    logic [63:0] req_addr   = '0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_wdata  = '0;
    logic        req_ready;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_fault;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_memory_sized dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; one request, response sampled at the next negedge.
    task automatic xact(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_flt);
        check({tag, "_ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_rdata"}, rsp_rdata, exp_rd);
        check({tag, "_fault"}, 64'(rsp_fault), 64'(exp_flt));
        @(negedge clk);
        check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        int bad_ready = 0;
        while (busy && n < 3000) begin
            if (req_ready) bad_ready++;
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'd1024);
        check({tag, "_ready_low"}, 64'(bad_ready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_fault", 64'(rsp_fault), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;

        wait_clear("t1");
        xact("t1_ld_top", 1'b0, F3_D, 64'h1FF8, 64'd0, 64'd0, 1'b0);

        xact("t2_sd", 1'b1, F3_D, 64'h10, 64'h1122334455667788, 64'd0, 1'b0);
        xact("t2_sb", 1'b1, F3_B, 64'h13, 64'h00000000000055AA, 64'd0, 1'b0);
        xact("t2_ld", 1'b0, F3_D, 64'h10, 64'd0, 64'h11223344AA667788, 1'b0);

        xact("t3_sd",  1'b1, F3_D,  64'h10, 64'h00000000000080FF, 64'd0, 1'b0);
        xact("t3_lb",  1'b0, F3_B,  64'h10, 64'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        xact("t3_lbu", 1'b0, F3_BU, 64'h11, 64'd0, 64'h0000000000000080, 1'b0);
        xact("t3_lh",  1'b0, F3_H,  64'h10, 64'd0, 64'hFFFFFFFFFFFF80FF, 1'b0);
        xact("t3_lhu", 1'b0, F3_HU, 64'h10, 64'd0, 64'h00000000000080FF, 1'b0);
        xact("t3_lw",  1'b0, F3_W,  64'h10, 64'd0, 64'h00000000000080FF, 1'b0);
        xact("t3_lwu", 1'b0, F3_WU, 64'h14, 64'd0, 64'd0, 1'b0);

        xact("t4_lw_mis",  1'b0, F3_W,   64'h12,   64'd0, 64'd0, 1'b1);
        xact("t4_sw_mis",  1'b1, F3_W,   64'h12,   64'hFFFFFFFF, 64'd0, 1'b1);
        xact("t4_sd_oor",  1'b1, F3_D,   64'h2000, 64'h1234, 64'd0, 1'b1);
        xact("t4_ld_f7",   1'b0, 3'b111, 64'h10,   64'd0, 64'd0, 1'b1);
        xact("t4_st_f4",   1'b1, F3_BU,  64'h10,   64'h77, 64'd0, 1'b1);
        xact("t4_ld_same", 1'b0, F3_D,   64'h10,   64'd0, 64'h00000000000080FF, 1'b0);
        xact("t4_sh_top",  1'b1, F3_H,   64'h1FFE, 64'hBEEF, 64'd0, 1'b0);
        xact("t4_ld_top",  1'b0, F3_D,   64'h1FF8, 64'd0, 64'hBEEF000000000000, 1'b0);

        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = F3_D;
        req_addr   = 64'h40;
        req_wdata  = 64'hDEAD;
        @(negedge clk);
        check("t5_st_valid", 64'(rsp_valid), 64'd1);
        check("t5_st_fault", 64'(rsp_fault), 64'd0);
        req_write = 1'b0;
        req_wdata = 64'd0;
        @(negedge clk);
        req_valid = 1'b0;
        check("t5_ld_valid", 64'(rsp_valid), 64'd1);
        check("t5_ld_rdata", rsp_rdata, 64'hDEAD);
        @(negedge clk);
        check("t5_pulse", 64'(rsp_valid), 64'd0);

        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = F3_D;
        req_addr   = 64'h10;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("t6_valid", 64'(rsp_valid), 64'd0);
        check("t6_busy", 64'(busy), 64'd1);
        check("t6_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("t6_valid_hold", 64'(rsp_valid), 64'd0);
        reset = 1'b1;
        repeat (100) @(negedge clk);
        check("t6_mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        wait_clear("t6");
        xact("t6_ld_lo",  1'b0, F3_D, 64'h10,   64'd0, 64'd0, 1'b0);
        xact("t6_ld_40",  1'b0, F3_D, 64'h40,   64'd0, 64'd0, 1'b0);
        xact("t6_ld_top", 1'b0, F3_D, 64'h1FF8, 64'd0, 64'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
